// File: rtl/pwm_csr_bank_if.sv
// Register-bus bundle between the AXI4-Lite slave decoder and the PWM CSR bank.
// Word-addressed single-cycle write strobe plus registered read with valid.
interface pwm_csr_bank_if #(
   parameter int NUM_CHANNELS = 4
);
   localparam int ADDR_WIDTH = $clog2(3 + 3 * NUM_CHANNELS);

   logic                  write_en;
   logic [ADDR_WIDTH-1:0] write_addr;
   logic [31:0]           write_data;
   logic [3:0]            write_strb;
   logic                  read_en;
   logic [ADDR_WIDTH-1:0] read_addr;
   logic [31:0]           read_data;
   logic                  read_valid;

   modport master (
      output write_en, write_addr, write_data, write_strb,
      output read_en, read_addr,
      input  read_data, read_valid
   );

   modport slave (
      input  write_en, write_addr, write_data, write_strb,
      input  read_en, read_addr,
      output read_data, read_valid
   );
endinterface

// File: rtl/pwm_csr_bank.sv
// PWM control/status register bank: shadow registers committed to the core
// at each channel's period wrap, with duty saturation and sticky W1C wrap IRQs.
module pwm_csr_bank #(
   parameter int REG_WIDTH    = 16,
   parameter int NUM_CHANNELS = 4
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   pwm_csr_bank_if.slave                          bus,
   input  logic [NUM_CHANNELS-1:0]                ch_wrap,
   output logic [REG_WIDTH-1:0]                   prescale,
   output logic [NUM_CHANNELS-1:0][REG_WIDTH-1:0] period,
   output logic [NUM_CHANNELS-1:0][REG_WIDTH-1:0] duty,
   output logic [NUM_CHANNELS-1:0]                ch_enable,
   output logic [NUM_CHANNELS-1:0]                ch_polarity,
   output logic                                   irq
);
   localparam int NC = NUM_CHANNELS;
   localparam int AW = $clog2(3 + 3 * NC);

   typedef logic [REG_WIDTH-1:0] field_t;

   function automatic field_t merge(
      input field_t      old,
      input logic [31:0] d,
      input logic [3:0]  s
   );
      logic [31:0] r;
      r = 32'(old);
      for (int b = 0; b < 4; b++)
         if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r[REG_WIDTH-1:0];
   endfunction

   logic          ctrl_en;
   field_t        pre_sh;
   field_t        per_sh [NC];
   field_t        dut_sh [NC];
   logic [2:0]    cfg_sh [NC];
   logic [NC-1:0] act_en;
   logic [NC-1:0] act_ie;
   logic [NC-1:0] pending;
   logic [NC-1:0] pend_nxt;
   logic [NC-1:0] commit;
   logic [NC-1:0] status;
   logic [NC-1:0] w1c;
   logic [NC-1:0] cfg_we;
   logic [NC-1:0] per_we;
   logic [NC-1:0] dut_we;
   logic          ctrl_we;
   logic          pre_we;
   logic          irq_we;
   logic          upd;
   logic          pre_load;
   logic [31:0]   rmux;

   always_comb begin
      ctrl_we = bus.write_en && bus.write_addr == AW'(0)
                && bus.write_strb[0];
      pre_we  = bus.write_en && bus.write_addr == AW'(1);
      irq_we  = bus.write_en && bus.write_addr == AW'(2);
      upd     = ctrl_we && bus.write_data[1];
      for (int i = 0; i < NC; i++) begin
         cfg_we[i] = bus.write_en && bus.write_strb[0]
                     && bus.write_addr == AW'(3 + 3 * i);
         per_we[i] = bus.write_en
                     && bus.write_addr == AW'(4 + 3 * i);
         dut_we[i] = bus.write_en
                     && bus.write_addr == AW'(5 + 3 * i);
         w1c[i]    = irq_we && bus.write_data[i]
                     && bus.write_strb[i/8];
      end
   end

   // An idle channel (or a globally disabled bank) has no cycle to protect
   assign ch_enable = act_en & {NC{ctrl_en}};
   assign commit    = pending & (ch_wrap | ~ch_enable);
   assign pend_nxt  = upd ? '1 : (pending & ~commit);
   assign pre_load  = (|pending) && (pend_nxt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_en <= 1'b0;
         pre_sh  <= '0;
         for (int i = 0; i < NC; i++) begin
            per_sh[i] <= '0;
            dut_sh[i] <= '0;
            cfg_sh[i] <= '0;
         end
      end else begin
         if (ctrl_we) ctrl_en <= bus.write_data[0];
         if (pre_we)
            pre_sh <= merge(pre_sh, bus.write_data, bus.write_strb);
         for (int i = 0; i < NC; i++) begin
            if (cfg_we[i]) cfg_sh[i] <= bus.write_data[2:0];
            if (per_we[i])
               per_sh[i] <= merge(per_sh[i], bus.write_data,
                                  bus.write_strb);
            if (dut_we[i])
               dut_sh[i] <= merge(dut_sh[i], bus.write_data,
                                  bus.write_strb);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending     <= '0;
         prescale    <= '0;
         period      <= '0;
         duty        <= '0;
         act_en      <= '0;
         act_ie      <= '0;
         ch_polarity <= '0;
      end else begin
         pending <= pend_nxt;
         if (pre_load) prescale <= pre_sh;
         for (int i = 0; i < NC; i++) begin
            if (commit[i]) begin
               period[i]      <= per_sh[i];
               duty[i]        <= (dut_sh[i] > per_sh[i]) ?
                                 per_sh[i] : dut_sh[i];
               act_en[i]      <= cfg_sh[i][0];
               ch_polarity[i] <= cfg_sh[i][1];
               act_ie[i]      <= cfg_sh[i][2];
            end
         end
      end
   end

   // A wrap in the same cycle as its W1C keeps the bit set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status <= '0;
         irq    <= 1'b0;
      end else begin
         status <= (status & ~w1c) | (ch_wrap & act_ie);
         irq    <= |status;
      end
   end

   always_comb begin
      rmux = '0;
      if (bus.read_addr == AW'(0)) rmux[0] = ctrl_en;
      if (bus.read_addr == AW'(1)) rmux = 32'(pre_sh);
      if (bus.read_addr == AW'(2)) begin
         rmux[NC-1:0]  = status;
         rmux[16 +: NC] = pending;
      end
      for (int i = 0; i < NC; i++) begin
         if (bus.read_addr == AW'(3 + 3 * i))
            rmux = 32'(cfg_sh[i]);
         if (bus.read_addr == AW'(4 + 3 * i))
            rmux = 32'(per_sh[i]);
         if (bus.read_addr == AW'(5 + 3 * i))
            rmux = 32'(dut_sh[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.read_data  <= '0;
         bus.read_valid <= 1'b0;
      end else begin
         bus.read_valid <= bus.read_en;
         if (bus.read_en) bus.read_data <= rmux;
      end
   end
endmodule

// File: tb/tb_pwm_csr_bank.sv
// Scoreboard bench for pwm_csr_bank: read data queued at issue, popped on
// read_valid; active outputs checked against hand-derived values.
module tb_pwm_csr_bank;
   localparam int RW = 16;
   localparam int NC = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic [NC-1:0]         ch_wrap;
   logic [RW-1:0]         prescale;
   logic [NC-1:0][RW-1:0] period;
   logic [NC-1:0][RW-1:0] duty;
   logic [NC-1:0]         ch_enable;
   logic [NC-1:0]         ch_polarity;
   logic                  irq;

   int n_run  = 0;
   int n_fail = 0;
   logic [31:0] exp_q [$];
   string       tag_q [$];

   always #5 clk = ~clk;

   pwm_csr_bank_if #(.NUM_CHANNELS(NC)) bus ();

   pwm_csr_bank #(
      .REG_WIDTH(RW),
      .NUM_CHANNELS(NC)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus),
      .ch_wrap(ch_wrap),
      .prescale(prescale),
      .period(period),
      .duty(duty),
      .ch_enable(ch_enable),
      .ch_polarity(ch_polarity),
      .irq(irq)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.read_valid === 1'b1) begin
         if (exp_q.size() == 0)
            chk("rd_spurious", 32'(exp_q.size()), 32'd1);
         else
            chk(tag_q.pop_front(), bus.read_data, exp_q.pop_front());
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d,
                     input logic [3:0] s = 4'hF);
      @(negedge clk);
      bus.write_en   = 1'b1;
      bus.write_addr = a;
      bus.write_data = d;
      bus.write_strb = s;
      @(negedge clk);
      bus.write_en = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [3:0] a,
                     input logic [31:0] exp);
      @(negedge clk);
      bus.read_en   = 1'b1;
      bus.read_addr = a;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(negedge clk);
      bus.read_en = 1'b0;
      chk({tag, "_valid"}, 32'(bus.read_valid), 32'd1);
   endtask

   task automatic pulse(input logic [NC-1:0] m);
      @(negedge clk);
      ch_wrap = m;
      @(negedge clk);
      ch_wrap = '0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_pre"}, 32'(prescale), 0);
      for (int i = 0; i < NC; i++) begin
         chk({tag, "_per"}, 32'(period[i]), 0);
         chk({tag, "_duty"}, 32'(duty[i]), 0);
      end
      chk({tag, "_en"}, 32'(ch_enable), 0);
      chk({tag, "_pol"}, 32'(ch_polarity), 0);
      chk({tag, "_irq"}, 32'(irq), 0);
      chk({tag, "_rv"}, 32'(bus.read_valid), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n          = 1'b0;
      ch_wrap        = '0;
      bus.write_en   = 1'b0;
      bus.write_addr = '0;
      bus.write_data = '0;
      bus.write_strb = '0;
      bus.read_en    = 1'b0;
      bus.read_addr  = '0;
      cyc(2);
      chk_zero("rst");
      rst_n = 1'b1;
      rd("rst_ctrl", 4'd0, 0);
      rd("rst_irqs", 4'd2, 0);
      rd("rst_per0", 4'd4, 0);
      rd("rst_bad", 4'd15, 0);

      wr(4'd4, 100);
      wr(4'd5, 40);
      wr(4'd3, 1);
      wr(4'd1, 7);
      wr(4'd0, 3);
      cyc(1);
      chk("init_per0", 32'(period[0]), 100);
      chk("init_duty0", 32'(duty[0]), 40);
      chk("init_en", 32'(ch_enable), 1);
      chk("init_pre", 32'(prescale), 7);
      rd("init_pend", 4'd2, 0);

      wr(4'd1, 9);
      wr(4'd5, 60);
      wr(4'd0, 3);
      cyc(3);
      chk("hold_duty0", 32'(duty[0]), 40);
      chk("hold_pre", 32'(prescale), 7);
      rd("hold_pend", 4'd2, 32'h0001_0000);
      pulse(4'b0001);
      chk("wrap_duty0", 32'(duty[0]), 60);
      chk("wrap_pre", 32'(prescale), 9);
      rd("wrap_pend", 4'd2, 0);

      wr(4'd8, 500);
      wr(4'd7, 200);
      wr(4'd0, 3);
      cyc(1);
      chk("sat_duty1", 32'(duty[1]), 200);
      chk("sat_per1", 32'(period[1]), 200);
      rd("sat_rb", 4'd8, 500);
      pulse(4'b0010);
      rd("np_wrap", 4'd2, 32'h0001_0000);
      pulse(4'b0001);
      rd("rearm_done", 4'd2, 0);

      wr(4'd5, 50);
      wr(4'd0, 2);
      chk("dis_en", 32'(ch_enable), 0);
      cyc(1);
      chk("dis_duty0", 32'(duty[0]), 50);
      rd("dis_pend", 4'd2, 0);
      wr(4'd0, 1);
      chk("reen_en", 32'(ch_enable), 1);

      wr(4'd4, 32'hFFFF_1234);
      rd("hi_ign", 4'd4, 32'h1234);
      wr(4'd4, 32'h0000_ABCD, 4'b0001);
      rd("strb", 4'd4, 32'h12CD);
      chk("strb_act", 32'(period[0]), 100);
      wr(4'd15, 32'hDEAD_BEEF);
      rd("bad_addr", 4'd15, 0);
      rd("ctrl_rb", 4'd0, 1);

      wr(4'd3, 5);
      wr(4'd0, 3);
      pulse(4'b0001);
      rd("ie_commit", 4'd2, 0);
      pulse(4'b0001);
      chk("irq_lag", 32'(irq), 0);
      cyc(1);
      chk("irq_set", 32'(irq), 1);
      rd("stat_set", 4'd2, 1);
      @(negedge clk);
      bus.write_en   = 1'b1;
      bus.write_addr = 4'd2;
      bus.write_data = 1;
      bus.write_strb = 4'hF;
      ch_wrap        = 4'b0001;
      @(negedge clk);
      bus.write_en = 1'b0;
      ch_wrap      = '0;
      rd("set_wins", 4'd2, 1);
      wr(4'd2, 1, 4'b0010);
      rd("w1c_nostrb", 4'd2, 1);
      wr(4'd2, 1);
      chk("irq_hold", 32'(irq), 1);
      cyc(1);
      chk("irq_clr", 32'(irq), 0);
      rd("stat_clr", 4'd2, 0);

      wr(4'd5, 77);
      wr(4'd0, 3);
      cyc(1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_zero("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      rd("mid_pend", 4'd2, 0);
      rd("mid_duty0", 4'd5, 0);
      rd("mid_ctrl", 4'd0, 0);
      pulse(4'b0001);
      chk("mid_nocommit", 32'(duty[0]), 0);

      cyc(2);
      chk("q_empty", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
